// File: rtl/mem_pkg.sv
// Shared encodings for the data-memory responder: access sizes, FSM states
// and the wait-state counter width.
package mem_pkg;
  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } stateT;
endpackage

// File: rtl/dm_lane_align.sv
// Little-endian lane steering: store byte enables and lane replication, load
// extraction with sign/zero extension, and misalignment detection.
module dm_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  reqSize,
  input  logic        reqUnsigned,
  input  logic [1:0]  addrLow,
  input  logic [31:0] storeData,
  input  logic [31:0] memWord,
  output logic [3:0]  byteEn,
  output logic [31:0] storeWord,
  output logic [31:0] loadData,
  output logic        misaligned
);
  logic [15:0] halfSel;
  logic [7:0]  byteSel;

  assign halfSel = addrLow[1] ? memWord[31:16] : memWord[15:0];
  assign byteSel = memWord[{addrLow, 3'b000} +: 8];

  always_comb begin
    byteEn     = 4'hF;
    storeWord  = storeData;
    loadData   = memWord;
    misaligned = 1'b0;
    case (reqSize)
      SZ_HALF: begin
        misaligned = addrLow[0];
        byteEn     = addrLow[1] ? 4'b1100 : 4'b0011;
        storeWord  = {2{storeData[15:0]}};
        loadData   = {{16{~reqUnsigned & halfSel[15]}}, halfSel};
      end
      SZ_BYTE: begin
        byteEn    = 4'b0001 << addrLow;
        storeWord = {4{storeData[7:0]}};
        loadData  = {{24{~reqUnsigned & byteSel[7]}}, byteSel};
      end
      // word and the reserved encoding both behave as a full-word access
      default: begin
        misaligned = (addrLow != 2'b00);
      end
    endcase
  end
endmodule

// File: rtl/dm_responder.sv
// Multi-cycle data-memory responder with programmable wait states and stall.
// Optional one-entry store buffer enabled by defining DM_STORE_BUFFER_EN.
module dm_responder
  import mem_pkg::*;
#(
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_rd,
  input  logic        req_wr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        err_misaligned
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_CYCLES - 1);

  logic [31:0]    mem [DEPTH];
  stateT          state;
  logic [CNT_W-1:0] cnt;

  logic           reqValid;
  logic [AW-1:0]  wordIdx;
  logic [3:0]     byteEn;
  logic [31:0]    storeWord;
  logic [31:0]    loadData;
  logic           misaligned;
  logic           unusedAddrHi;

  logic           blocked;
  logic           bufCapture;
  logic           bufDrain;
  logic           fsmStart;
  logic           loadDone;

  logic           memWe;
  logic [AW-1:0]  memIdx;
  logic [3:0]     memBe;
  logic [31:0]    memData;

  assign reqValid     = req_rd | req_wr;
  assign wordIdx      = req_addr[AW+1:2];
  assign unusedAddrHi = ^req_addr[31:AW+2];

  dm_lane_align uAlign (
    .reqSize    (req_size),
    .reqUnsigned(req_unsigned),
    .addrLow    (req_addr[1:0]),
    .storeData  (req_wdata),
    .memWord    (mem[wordIdx]),
    .byteEn     (byteEn),
    .storeWord  (storeWord),
    .loadData   (loadData),
    .misaligned (misaligned)
  );

`ifdef DM_STORE_BUFFER_EN
  localparam bit USE_BUF = (WAIT_CYCLES > 0);
  localparam logic [CNT_W-1:0] WAIT_FULL = CNT_W'(WAIT_CYCLES);

  logic             bufValid;
  logic [CNT_W-1:0] bufCnt;
  logic [AW-1:0]    bufIdx;
  logic [3:0]       bufBe;
  logic [31:0]      bufData;

  // the drain cycle frees the entry, so a new request is allowed to proceed in it
  assign bufDrain   = bufValid && (bufCnt == CNT_ONE);
  assign blocked    = bufValid && !bufDrain;
  assign bufCapture = USE_BUF && (state == IDLE) && req_wr && !misaligned && !blocked;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bufValid <= 1'b0;
      bufCnt   <= '0;
    end else if (bufCapture) begin
      bufValid <= 1'b1;
      bufCnt   <= WAIT_FULL;
    end else if (bufDrain) begin
      bufValid <= 1'b0;
      bufCnt   <= '0;
    end else if (bufValid) begin
      bufCnt   <= bufCnt - CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (bufCapture) begin
      bufIdx  <= wordIdx;
      bufBe   <= byteEn;
      bufData <= storeWord;
    end
  end
`else
  assign blocked    = 1'b0;
  assign bufCapture = 1'b0;
  assign bufDrain   = 1'b0;
`endif

  assign fsmStart = (WAIT_CYCLES > 0) && (state == IDLE) && reqValid &&
                    !misaligned && !blocked && !bufCapture;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (fsmStart) begin
            state <= (WAIT_CYCLES == 1) ? DONE : WAIT;
            cnt   <= (WAIT_CYCLES == 1) ? '0 : WAIT_LOAD;
          end
        end
        WAIT: begin
          if (!reqValid) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt - CNT_ONE;
            if (cnt == CNT_ONE) state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign loadDone = req_rd && !misaligned &&
                    ((state == DONE) || ((state == IDLE) && (WAIT_CYCLES == 0)));

  assign stall = !rst && (((state == IDLE) && reqValid && (blocked || fsmStart)) ||
                          ((state == WAIT) && reqValid));
  assign err_misaligned = !rst && (state == IDLE) && reqValid && misaligned && !blocked;
  assign rdata = (!rst && loadDone) ? loadData : '0;

  always_comb begin
    memWe   = 1'b0;
    memIdx  = wordIdx;
    memBe   = byteEn;
    memData = storeWord;
`ifdef DM_STORE_BUFFER_EN
    if (bufDrain && !rst) begin
      memWe   = 1'b1;
      memIdx  = bufIdx;
      memBe   = bufBe;
      memData = bufData;
    end else
`endif
    if (!rst && req_wr && !misaligned && !bufCapture &&
        ((state == DONE) || ((state == IDLE) && (WAIT_CYCLES == 0)))) begin
      memWe = 1'b1;
    end
  end

  // array has no reset; contents survive a mid-operation reset
  always_ff @(posedge clk) begin
    if (memWe) begin
      for (int i = 0; i < 4; i++) begin
        if (memBe[i]) mem[memIdx][8*i +: 8] <= memData[8*i +: 8];
      end
    end
  end
endmodule

// File: tb/tb_dm_responder.sv
// Directed bench for dm_responder: table-driven accesses at WAIT_CYCLES=2 plus
// hand-written reset, flush, zero-wait and store-buffer sequences.
module tb_dm_responder;
  import mem_pkg::*;

`ifdef DM_STORE_BUFFER_EN
  localparam bit BUF = 1'b1;
`else
  localparam bit BUF = 1'b0;
`endif
  localparam int SST = BUF ? 0 : 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd [3];
  logic        wr [3];
  logic [1:0]  sz [3];
  logic        uns [3];
  logic [31:0] addr [3];
  logic [31:0] wdata [3];
  logic [31:0] rdataO [3];
  logic        stallO [3];
  logic        errO [3];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dm_responder #(.DEPTH(1024), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .req_rd(rd[0]), .req_wr(wr[0]), .req_size(sz[0]),
    .req_unsigned(uns[0]), .req_addr(addr[0]), .req_wdata(wdata[0]),
    .rdata(rdataO[0]), .stall(stallO[0]), .err_misaligned(errO[0]));

  dm_responder #(.DEPTH(1024), .WAIT_CYCLES(2)) dut2 (
    .clk(clk), .rst(rst), .req_rd(rd[1]), .req_wr(wr[1]), .req_size(sz[1]),
    .req_unsigned(uns[1]), .req_addr(addr[1]), .req_wdata(wdata[1]),
    .rdata(rdataO[1]), .stall(stallO[1]), .err_misaligned(errO[1]));

  dm_responder #(.DEPTH(1024), .WAIT_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst), .req_rd(rd[2]), .req_wr(wr[2]), .req_size(sz[2]),
    .req_unsigned(uns[2]), .req_addr(addr[2]), .req_wdata(wdata[2]),
    .rdata(rdataO[2]), .stall(stallO[2]), .err_misaligned(errO[2]));

  typedef struct {
    string       name;
    logic        rd;
    logic        wr;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] expR;
    logic        expErr;
    int          expStall;
  } vecT;

  vecT vecs[$];

  function automatic vecT mk(string n, logic r, logic w, logic [1:0] s, logic u,
                             logic [31:0] a, logic [31:0] d, logic [31:0] er,
                             logic ee, int es);
    vecT v;
    v.name = n; v.rd = r; v.wr = w; v.sz = s; v.uns = u; v.addr = a;
    v.wdata = d; v.expR = er; v.expErr = ee; v.expStall = es;
    return v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clearReq(input int k);
    rd[k] = 1'b0; wr[k] = 1'b0; sz[k] = 2'b00; uns[k] = 1'b0;
    addr[k] = '0; wdata[k] = '0;
  endtask

  task automatic setReq(input int k, input logic r, input logic w, input logic [1:0] s,
                        input logic u, input logic [31:0] a, input logic [31:0] d);
    rd[k] = r; wr[k] = w; sz[k] = s; uns[k] = u; addr[k] = a; wdata[k] = d;
  endtask

  // Waits for the completion cycle of the request already on the inputs.
  task automatic waitDone(input int k, output int stalls, output logic [31:0] rv,
                          output logic ev, output logic zeroOk);
    bit done = 1'b0;
    stalls = 0; rv = '0; ev = 1'b0; zeroOk = 1'b1;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (stallO[k]) begin
        stalls++;
        if (rdataO[k] != 32'h0) zeroOk = 1'b0;
        @(posedge clk); #1;
      end else begin
        rv = rdataO[k]; ev = errO[k]; done = 1'b1;
      end
    end
    if (!done) stalls = -1;
    @(posedge clk); #1;
    clearReq(k);
  endtask

  task automatic access(input int k, input logic r, input logic w, input logic [1:0] s,
                        input logic u, input logic [31:0] a, input logic [31:0] d,
                        output int stalls, output logic [31:0] rv, output logic ev,
                        output logic zeroOk);
    @(posedge clk); #1;
    setReq(k, r, w, s, u, a, d);
    waitDone(k, stalls, rv, ev, zeroOk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int st;
    logic [31:0] rv;
    logic ev, zok;

    rst = 1'b1;
    for (int k = 0; k < 3; k++) clearReq(k);
    #2;
    check("reset_stall", 32'(stallO[1]), 32'h0);
    check("reset_rdata", rdataO[1], 32'h0);
    check("reset_err", 32'(errO[1]), 32'h0);
    check("reset_state", 32'(dut2.state), 32'(IDLE));
    check("reset_cnt", 32'(dut2.cnt), 32'h0);
    setReq(1, 1'b1, 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0);
    #1;
    check("reset_stall_req_held", 32'(stallO[1]), 32'h0);
    clearReq(1);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    vecs.push_back(mk("sw_10",    0, 1, SZ_WORD, 0, 32'h10,   32'hDEADBEEF, 32'h0,        0, SST));
    vecs.push_back(mk("lw_10",    1, 0, SZ_WORD, 0, 32'h10,   32'h0,        32'hDEADBEEF, 0, 2));
    vecs.push_back(mk("sw_20",    0, 1, SZ_WORD, 0, 32'h20,   32'h80F17F02, 32'h0,        0, SST));
    vecs.push_back(mk("lb_23",    1, 0, SZ_BYTE, 0, 32'h23,   32'h0,        32'hFFFFFF80, 0, 2));
    vecs.push_back(mk("lbu_23",   1, 0, SZ_BYTE, 1, 32'h23,   32'h0,        32'h00000080, 0, 2));
    vecs.push_back(mk("lh_20",    1, 0, SZ_HALF, 0, 32'h20,   32'h0,        32'h00007F02, 0, 2));
    vecs.push_back(mk("lhu_22",   1, 0, SZ_HALF, 1, 32'h22,   32'h0,        32'h000080F1, 0, 2));
    vecs.push_back(mk("lh_22",    1, 0, SZ_HALF, 0, 32'h22,   32'h0,        32'hFFFF80F1, 0, 2));
    vecs.push_back(mk("lb_21",    1, 0, SZ_BYTE, 0, 32'h21,   32'h0,        32'h0000007F, 0, 2));
    vecs.push_back(mk("sw_20b",   0, 1, SZ_WORD, 0, 32'h20,   32'h11223344, 32'h0,        0, SST));
    vecs.push_back(mk("sb_21",    0, 1, SZ_BYTE, 0, 32'h21,   32'hFFFFFFAA, 32'h0,        0, SST));
    vecs.push_back(mk("lw_20_sb", 1, 0, SZ_WORD, 0, 32'h20,   32'h0,        32'h1122AA44, 0, 2));
    vecs.push_back(mk("sh_22",    0, 1, SZ_HALF, 0, 32'h22,   32'h5566BEEF, 32'h0,        0, SST));
    vecs.push_back(mk("lw_20_sh", 1, 0, SZ_WORD, 0, 32'h20,   32'h0,        32'hBEEFAA44, 0, 2));
    vecs.push_back(mk("lw_rsvd",  1, 0, 2'b11,   0, 32'h20,   32'h0,        32'hBEEFAA44, 0, 2));
    vecs.push_back(mk("lw_06_mis",1, 0, SZ_WORD, 0, 32'h06,   32'h0,        32'h0,        1, 0));
    vecs.push_back(mk("lh_21_mis",1, 0, SZ_HALF, 0, 32'h21,   32'h0,        32'h0,        1, 0));
    vecs.push_back(mk("sw_13_mis",0, 1, SZ_WORD, 0, 32'h13,   32'hCCCCCCCC, 32'h0,        1, 0));
    vecs.push_back(mk("lw_10_kept",1,0, SZ_WORD, 0, 32'h10,   32'h0,        32'hDEADBEEF, 0, 2));
    vecs.push_back(mk("lw_1010",  1, 0, SZ_WORD, 0, 32'h1010, 32'h0,        32'hDEADBEEF, 0, 2));
    vecs.push_back(mk("sw_1010",  0, 1, SZ_WORD, 0, 32'h1010, 32'hCAFEF00D, 32'h0,        0, SST));
    vecs.push_back(mk("lw_10_wrap",1,0, SZ_WORD, 0, 32'h10,   32'h0,        32'hCAFEF00D, 0, 2));
    vecs.push_back(mk("sw_40_zero",0,1, SZ_WORD, 0, 32'h40,   32'h0,        32'h0,        0, SST));

    foreach (vecs[i]) begin
      access(1, vecs[i].rd, vecs[i].wr, vecs[i].sz, vecs[i].uns, vecs[i].addr,
             vecs[i].wdata, st, rv, ev, zok);
      check({vecs[i].name, "_stall"}, 32'(st), 32'(vecs[i].expStall));
      check({vecs[i].name, "_rdata"}, rv, vecs[i].expR);
      check({vecs[i].name, "_err"}, 32'(ev), 32'(vecs[i].expErr));
      check({vecs[i].name, "_rdata_zero_while_stalled"}, 32'(zok), 32'h1);
    end

    // Reset in WAIT: stall drops at once, FSM back to IDLE, store discarded
    @(posedge clk); #1;
    setReq(1, BUF, !BUF, SZ_WORD, 1'b0, 32'h40, 32'hFFFFFFFF);
    @(posedge clk); #1;
    if (!BUF) check("rstmid_state_wait", 32'(dut2.state), 32'(WAIT));
    check("rstmid_stall_before", 32'(stallO[1]), 32'h1);
    rst = 1'b1;
    #1;
    check("rstmid_stall_after", 32'(stallO[1]), 32'h0);
    check("rstmid_state_idle", 32'(dut2.state), 32'(IDLE));
    check("rstmid_cnt", 32'(dut2.cnt), 32'h0);
    clearReq(1);
    @(posedge clk); #1;
    rst = 1'b0;
    access(1, 1'b1, 1'b0, SZ_WORD, 1'b0, 32'h40, 32'h0, st, rv, ev, zok);
    check("rstmid_store_discarded", rv, 32'h0);
    access(1, 1'b1, 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, st, rv, ev, zok);
    check("rstmid_array_kept", rv, 32'hCAFEF00D);

    // Flush: request drops during WAIT, stall falls that cycle, no write
    @(posedge clk); #1;
    setReq(1, BUF, !BUF, SZ_WORD, 1'b0, 32'h40, 32'h77777777);
    @(posedge clk); #1;
    clearReq(1);
    @(negedge clk);
    check("flush_stall", 32'(stallO[1]), 32'h0);
    @(posedge clk); #1;
    check("flush_state", 32'(dut2.state), 32'(IDLE));
    access(1, 1'b1, 1'b0, SZ_WORD, 1'b0, 32'h40, 32'h0, st, rv, ev, zok);
    check("flush_no_write", rv, 32'h0);
    check("flush_load_stall", 32'(st), 32'h2);

    // WAIT_CYCLES=0: back-to-back store then load of the same word
    @(posedge clk); #1;
    setReq(0, 1'b0, 1'b1, SZ_WORD, 1'b0, 32'h10, 32'h0BADCAFE);
    @(negedge clk);
    check("w0_store_stall", 32'(stallO[0]), 32'h0);
    @(posedge clk); #1;
    setReq(0, 1'b1, 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0);
    @(negedge clk);
    check("w0_load_stall", 32'(stallO[0]), 32'h0);
    check("w0_load_rdata", rdataO[0], 32'h0BADCAFE);
    @(posedge clk); #1;
    setReq(0, 1'b1, 1'b0, SZ_BYTE, 1'b1, 32'h13, 32'h0);
    @(negedge clk);
    check("w0_lbu_13", rdataO[0], 32'h0000000B);
    @(posedge clk); #1;
    setReq(0, 1'b1, 1'b0, SZ_WORD, 1'b0, 32'h02, 32'h0);
    @(negedge clk);
    check("w0_mis_err", 32'(errO[0]), 32'h1);
    check("w0_mis_rdata", rdataO[0], 32'h0);
    @(posedge clk); #1;
    clearReq(0);
    @(negedge clk);
    check("w0_err_pulse_end", 32'(errO[0]), 32'h0);

    // WAIT_CYCLES=3
`ifdef DM_STORE_BUFFER_EN
    @(posedge clk); #1;
    setReq(2, 1'b0, 1'b1, SZ_WORD, 1'b0, 32'h50, 32'hA5A55A5A);
    @(negedge clk);
    check("buf_store_stall", 32'(stallO[2]), 32'h0);
    @(posedge clk); #1;
    setReq(2, 1'b1, 1'b0, SZ_WORD, 1'b0, 32'h50, 32'h0);
    waitDone(2, st, rv, ev, zok);
    check("buf_load_stall", 32'(st), 32'h5);
    check("buf_load_rdata", rv, 32'hA5A55A5A);
`else
    access(2, 1'b0, 1'b1, SZ_WORD, 1'b0, 32'h50, 32'hA5A55A5A, st, rv, ev, zok);
    check("w3_store_stall", 32'(st), 32'h3);
    access(2, 1'b1, 1'b0, SZ_WORD, 1'b0, 32'h50, 32'h0, st, rv, ev, zok);
    check("w3_load_stall", 32'(st), 32'h3);
    check("w3_load_rdata", rv, 32'hA5A55A5A);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/dm_responder.md
# dm_responder

Multi-cycle data-memory responder serving the pipeline's MEM-stage load/store requests. Holds a word-organised RAM and inserts programmable wait states. Raises a stall that freezes PC, IF/ID, ID/EX and EX/MEM until the access completes. Performs byte/half/word lane steering with sign or zero extension on loads.

## Interface

- `DEPTH`, default 1024: number of 32-bit words in the array; must be a power of two.
- `WAIT_CYCLES`, default 2: stall cycles per access, range 0–15.
- `clk` input, 1 bit: single clock, rising edge.
- `rst` input, 1 bit: reset, asynchronous and active-high.
- `req_rd` input, 1 bit: load request from EX/MEM.
- `req_wr` input, 1 bit: store request from EX/MEM. `req_rd` and `req_wr` are never both high.
- `req_size` input, 2 bits: 00 word, 01 half, 10 byte, 11 reserved (treated as word).
- `req_unsigned` input, 1 bit: 1 selects zero-extension on loads, 0 selects sign-extension.
- `req_addr` input, 32 bits: byte address (ALU result).
- `req_wdata` input, 32 bits: store data, right-aligned.
- `rdata` output, 32 bits: extended load data, valid in the completion cycle.
- `stall` output, 1 bit: pipeline hold; request inputs are held stable while it is high.
- `err_misaligned` output, 1 bit: one-cycle pulse marking a misaligned request.

## Operation

- States:
  - IDLE: no access in flight.
  - WAIT: counting down wait states.
  - DONE: completion cycle.
- Word index is `req_addr[log2(DEPTH)+1:2]`. Addresses beyond DEPTH wrap modulo DEPTH.
- Byte order is little-endian.
  - Byte lane = `addr[1:0]`.
  - Half lane = `addr[1]`.
- Stores write only the selected lanes; the other bytes are preserved.
- Misaligned means either:
  - a half access with `addr[0]`=1, or
  - a word access with `addr[1:0]`≠0.
- On a misaligned request:
  - `err_misaligned`=1 for one cycle.
  - No array access; `rdata`=0.
  - `stall`=0, so the request retires immediately.
- IDLE with a valid request:
  - If `WAIT_CYCLES`=0: complete in the same cycle (combinational read, store at the clock edge); stay in IDLE; `stall`=0.
  - Otherwise: `stall`=1 combinationally; load counter with `WAIT_CYCLES`-1; go to WAIT.
- WAIT:
  - `stall`=1.
  - Counter decrements each cycle.
  - When the counter is 0, go to DONE.
- DONE:
  - `stall`=0.
  - Loads drive `rdata`; stores commit at the end of this cycle.
  - Go to IDLE unconditionally. The request seen in IDLE on the following cycle is a new request, because the pipeline advanced.
- A request that drops while in WAIT (flush) aborts the access:
  - Return to IDLE with no write.
  - `stall` falls in that cycle.
- Reset mid-operation:
  - FSM returns to IDLE and the counter clears.
  - Any in-flight store is discarded.
  - Array contents are not cleared.

## Timing

- Reset values: `stall`=0, `rdata`=0, `err_misaligned`=0, FSM in IDLE, counter=0.
- `stall` is Mealy in IDLE (same cycle as the request) and Moore in WAIT.
- Aligned access latency is `WAIT_CYCLES`+1 cycles, of which `stall` is high for `WAIT_CYCLES` cycles.
- `rdata` is valid only in the completion cycle. It is 0 in all other cycles and for stores.
- Back-to-back requests each pay full latency; there is no pipelining between accesses.

## Configuration

- Macro `DM_STORE_BUFFER_EN`. When defined:
  - A one-entry store buffer is added.
  - A store in IDLE is captured into the buffer with `stall`=0; the pipeline does not wait for stores.
  - The buffer drains into the array after `WAIT_CYCLES` cycles.
  - Any request arriving while the buffer is occupied sees `stall`=1 until the drain completes, then starts its own access. A store arriving in the drain-completion cycle is captured without stall.
  - Reset invalidates the buffer.
- When `DM_STORE_BUFFER_EN` is undefined, stores stall exactly like loads.

## Structure

- Package `mem_pkg` holds:
  - the `req_size` encodings (`SZ_WORD`, `SZ_HALF`, `SZ_BYTE`);
  - the state enum (IDLE/WAIT/DONE);
  - the `WAIT_CYCLES` counter width constant (4).
- Sub-module `dm_lane_align`, purely combinational, does:
  - store byte-enable and data replication;
  - load lane extraction with sign/zero extension;
  - misalignment detection.
- The FSM, counter, array and optional store buffer stay in `dm_responder`.

## Test plan

- Reset values and word store/load, `WAIT_CYCLES`=2:
  - Assert `rst` during a WAIT → `stall`=0 and FSM in IDLE immediately, asynchronously.
  - Store word 0xDEADBEEF at 0x10 → `stall` high for 2 cycles.
  - Load word from 0x10 → `stall` high for 2 cycles, then `rdata`=0xDEADBEEF in the third cycle.
- Sub-word loads after storing 0x80F1_7F02 at 0x20:
  - `lb` 0x23 → 0xFFFFFF80.
  - `lbu` 0x23 → 0x00000080.
  - `lh` 0x20 → 0x00007F02.
  - `lhu` 0x22 → 0x000080F1.
- Byte store to 0x21 with data 0xAA over word 0x11223344 → word reads 0x1122AA44.
- Misaligned and wrap:
  - Word load at 0x06 → `err_misaligned` pulse, `stall`=0, `rdata`=0.
  - With `DEPTH`=1024, address 0x1010 aliases 0x0010.
- `WAIT_CYCLES`=0: back-to-back store then load of the same word → `stall` never rises and the load returns the stored value.
- `DM_STORE_BUFFER_EN`, `WAIT_CYCLES`=3:
  - Store → no stall.
  - Load issued the next cycle → stalls until the drain completes, then pays its own 3-wait-state access; total stall 5 cycles, then returns the stored data.
